// File: rtl/btn_uart_pkg.sv
// Shared types for the button-triggered UART reporter: FSM state encoding and line levels.
// BTN_UART_PARITY_EN adds an even-parity bit; the PARITY state is always declared.
package btn_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;

    function automatic logic even_parity(input logic [15:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises an active-low button, debounces it and emits a one-cycle press pulse
// on each accepted rising edge of the cleaned level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_prev_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= ~btn_n;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/btn_uart_reporter.sv
// Counts debounced button presses and sends each new count as an 8N1-style frame on tx,
// with a one-deep press queue and sticky overrun. BTN_UART_PARITY_EN adds even parity.
module btn_uart_reporter
    import btn_uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT     = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DATA_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    output logic              tx,
    output logic              busy,
    output logic [DATA_W-1:0] press_count,
    output logic              overrun
);

    localparam int unsigned BaudW = $clog2(CLK_PER_BIT);
    localparam int unsigned IdxW  = $clog2(DATA_W);

    state_e            state_q;
    logic [BaudW-1:0]  baud_q;
    logic [IdxW-1:0]   bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] count_inc;
    logic [DATA_W-1:0] reload_val;
    logic              pending_q;
    logic              overrun_q;
    logic              tx_q;
    logic              tx_level;
    logic              press;
    logic              bit_end;
`ifdef BTN_UART_PARITY_EN
    logic              parity_q;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn_n(btn_n),
        .press(press)
    );

    assign count_inc = count_q + DATA_W'(1);
    assign bit_end   = (baud_q == BaudW'(CLK_PER_BIT - 1));
    // A press landing in the final STOP cycle is folded into the back-to-back frame.
    assign reload_val = press ? count_inc : count_q;

    always_comb begin
        tx_level = TX_IDLE;
        unique case (state_q)
            StIdle:   tx_level = TX_IDLE;
            StStart:  tx_level = TX_START;
            StData:   tx_level = shift_q[0];
`ifdef BTN_UART_PARITY_EN
            StParity: tx_level = parity_q;
`else
            StParity: tx_level = TX_IDLE;
`endif
            StStop:   tx_level = TX_IDLE;
            default:  tx_level = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            tx_q      <= TX_IDLE;
`ifdef BTN_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            tx_q <= tx_level;

            if (press) begin
                count_q <= count_inc;
            end

            if (state_q != StIdle) begin
                baud_q <= bit_end ? '0 : baud_q + BaudW'(1);
                if (press) begin
                    if (pending_q) begin
                        overrun_q <= 1'b1;
                    end else begin
                        pending_q <= 1'b1;
                    end
                end
            end

            case (state_q)
                StIdle: begin
                    if (press) begin
                        shift_q <= count_inc;
`ifdef BTN_UART_PARITY_EN
                        parity_q <= even_parity(16'(count_inc));
`endif
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == IdxW'(DATA_W - 1)) begin
`ifdef BTN_UART_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + IdxW'(1);
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (pending_q || press) begin
                            shift_q   <= reload_val;
`ifdef BTN_UART_PARITY_EN
                            parity_q  <= even_parity(16'(reload_val));
`endif
                            pending_q <= 1'b0;
                            state_q   <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx          = tx_q;
    assign busy        = (state_q != StIdle);
    assign press_count = count_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/btn_uart_reporter.md
Name: btn_uart_reporter

Overview:
Button-triggered UART frame generator for the board-level demo path. It takes an active-low push button and synchronises and debounces it. Each clean press increments a press counter, and the block transmits the new count as a standard 8N1-style serial frame on tx. It is the parametrised successor to the fixed-width single-shot tx pulser, adding a real baud divider, a bit-serial frame, a one-deep press queue and overrun reporting.

Parameters:
CLK_PER_BIT, 100, clock cycles per serial bit; legal range is 2 or more.
DEBOUNCE_CYCLES, 16, consecutive stable synced samples required to accept a level change; legal range is 1 or more.
DATA_W, 8, press counter width and data bits per frame; legal range is 5 to 9.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
btn_n  input  1  raw push button, active-low, asynchronous to clk
tx  output  1  serial line, idle high; registered
busy  output  1  high while a frame is in flight (state != IDLE)
press_count  output  DATA_W  number of accepted presses, modulo 2^DATA_W
overrun  output  1  sticky; a press arrived while the one-deep queue was already full

Behaviour:
- Reset values: tx=1, busy=0, press_count=0, overrun=0, FSM=IDLE, pending=0, sync FFs=0, stable=0, debounce count=0, baud count=0.
- Input path:
  - btn = ~btn_n passes through a 2-FF synchroniser.
  - The debounce counter clears whenever the synced value equals stable; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES, stable takes the synced value and the counter clears.
  - press = a one-cycle pulse on a registered rising edge of stable.
- On a press:
  - press_count increments, wrapping from 2^DATA_W-1 to 0.
  - If FSM=IDLE, the shift register loads the incremented count and FSM moves to START on the next edge.
  - If busy and pending=0, set pending.
  - If busy and pending=1, set overrun. overrun clears only on rst.
- FSM states IDLE, START, DATA, STOP:
  - Each non-IDLE state lasts exactly CLK_PER_BIT cycles, timed by a baud counter running 0..CLK_PER_BIT-1.
  - DATA sends DATA_W bits, LSB first; the shift register shifts right at the end of each bit period.
  - At the end of STOP: if pending=1, reload from the current press_count, clear pending and go to START with no idle gap; otherwise go to IDLE.
- tx levels: IDLE=1, START=0, DATA=shift[0], STOP=1. tx is registered, so it follows the state by one cycle.
- Latency: with a clean btn_n fall after reset, tx falls exactly DEBOUNCE_CYCLES+4 clock edges later.
- Frame length: (DATA_W+2)*CLK_PER_BIT cycles; busy stays high for exactly that many cycles per frame.
- Simultaneous events:
  - A press in the last cycle of STOP sets pending, and that press is included in the back-to-back frame.
  - A press in the same cycle as rst is ignored.
- Reset mid-frame: the next edge forces tx=1 and busy=0 and clears the queue and count. No partial frame is resumed.
- Release bounces shorter than DEBOUNCE_CYCLES never produce a press.

Optional Feature:
- Macro BTN_UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP and transmits even parity (XOR of the DATA_W data bits). Frame length becomes (DATA_W+3)*CLK_PER_BIT.
- When undefined: no parity state, and the frame is as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package btn_uart_pkg holds the FSM state enum (IDLE, START, DATA, PARITY, STOP; PARITY is always declared) and localparams TX_IDLE=1'b1 and TX_START=1'b0.
- One sub-module, btn_debounce, contains the synchroniser, debounce counter and rising-edge pulse. It is parametrised by DEBOUNCE_CYCLES; its ports are clk, rst, btn_n and press.
- The top level holds the counter, queue, baud counter, FSM and shifter.

Test Plan:
- Bench parameters for all scenarios: CLK_PER_BIT=4, DEBOUNCE_CYCLES=3, DATA_W=8.
- Single press: one press after reset -> tx falls at edge 7; frame is 0, 1,0,0,0,0,0,0,0, 1, each level held 4 cycles; press_count=1; busy high for 40 cycles.
- Bounce: btn_n toggled every 2 cycles for 20 cycles, then held low -> exactly one press and one frame with payload 0x01.
- Queue: a second press during frame 1, and a third press after frame 1 ends -> frames carry 0x01, then 0x02 back-to-back with no idle gap, then 0x03; overrun=0.
- Overrun: three presses inside one frame -> overrun=1; two frames are sent, the second carrying press_count=0x03; press_count ends at 3.
- Wrap and reset: 256 presses -> press_count wraps to 0x00; rst asserted mid-DATA -> next edge gives tx=1, busy=0, press_count=0, overrun=0.
- Parity build: with BTN_UART_PARITY_EN defined, payload 0x03 -> parity bit 0 and a 44-cycle frame; payload 0x01 -> parity bit 1.
